// File: rtl/csr_test_monitor.sv
// On-chip pass/fail/timeout monitor for the CPU tohost CSR, with a one-byte result handshake.
// Optional build macro CSR_DOUBLE_SAMPLE_EN adds a glitch-rejecting double sample of csr.
module csr_test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      csr,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      fail_id,
    output logic [CNT_W-1:0] cycle_count,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [7:0]       result_code
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    localparam logic [7:0] CODE_PASS    = 8'h50;
    localparam logic [7:0] CODE_FAIL    = 8'h46;
    localparam logic [7:0] CODE_TIMEOUT = 8'h54;

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             csr_hit;
    logic [30:0]      csr_id;

    assign csr_id = csr[31:1];

`ifdef CSR_DOUBLE_SAMPLE_EN
    logic [31:0] csr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q <= '0;
        end else begin
            csr_q <= csr;
        end
    end

    // A done indication must look identical on two consecutive edges to count.
    assign csr_hit = csr[0] && (csr_q == csr);
`else
    assign csr_hit = csr[0];
`endif

    assign busy         = (state == S_RUN);
    assign result_valid = (state == S_REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            counter     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_id     <= '0;
            cycle_count <= '0;
            result_code <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    counter     <= '0;
                    done        <= 1'b0;
                    pass        <= 1'b0;
                    fail        <= 1'b0;
                    timeout     <= 1'b0;
                    fail_id     <= '0;
                    cycle_count <= '0;
                    result_code <= 8'h00;
                    if (start) begin
                        state <= S_RUN;
                    end
                end

                // A csr verdict outranks a timeout landing on the same edge.
                S_RUN: begin
                    if (csr_hit) begin
                        done        <= 1'b1;
                        cycle_count <= counter;
                        state       <= S_REPORT;
                        if (csr_id == 31'd0) begin
                            pass        <= 1'b1;
                            result_code <= CODE_PASS;
                        end else begin
                            fail        <= 1'b1;
                            fail_id     <= csr_id;
                            result_code <= CODE_FAIL;
                        end
                    end else if (counter == LAST_COUNT) begin
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                        cycle_count <= counter;
                        result_code <= CODE_TIMEOUT;
                        state       <= S_REPORT;
                    end else begin
                        counter <= counter + ONE;
                    end
                end

                S_REPORT: begin
                    if (result_ready) begin
                        state <= S_HALT;
                    end
                end

                S_HALT: begin
                    if (start) begin
                        state       <= S_RUN;
                        counter     <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_id     <= '0;
                        cycle_count <= '0;
                        result_code <= 8'h00;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
